multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for a multicycle MIPS-style datapath.
//
// Parameters
//   ALUOP_W     - width of ALUOp; the 4-bit operation codes are zero-extended.
//   MEM_TIMEOUT - consecutive mem_ready-low cycles tolerated in an access state
//                 before the controller faults (1..255).
//
// Ports
//   clk, reset_n          - rising-edge clock, asynchronous active-low reset
//   op[5:0]               - opcode from the instruction register
//   zero                  - ALU zero flag (branch resolution)
//   mem_ready             - memory access completes this cycle
//   PCWrite .. ExtMode    - 1-bit datapath controls
//   RegDst, ALUSrcB,
//   PCSource [1:0]        - multi-bit datapath selects
//   ALUOp[ALUOP_W-1:0]    - ALU operation code
//   state[3:0]            - current FSM state
//   error                 - sticky fault, cleared only by reset
module multicycle_control #(
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               PCToReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               ExtMode,
  output logic [1:0]         RegDst,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         state,
  output logic               error
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_ERROR  = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLT   = 4'b0100;
  localparam logic [3:0] ALU_AND   = 4'b1000;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       waiting;
  logic [3:0] aluop4;
  logic [3:0] imm_aluop;
  logic       imm_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:                          state_d = S_REXEC;
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J, OP_JAL:                      state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_XORI, OP_SLTI: state_d = S_IEXEC;
          default:                           state_d = S_ERROR;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_REXEC:  state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase
    // A stall only counts while mem_ready is low, so a completing access in
    // the timeout cycle wins; any state change leaves the counter cleared.
    if (waiting && !mem_ready) begin
      if (wcnt_q == TIMEOUT) state_d = S_ERROR;
      else                   wcnt_d  = wcnt_q + 8'd1;
    end
  end

  // ALU operation and extension mode shared by IEXEC and IWB.
  always_comb begin
    imm_aluop = ALU_ADD;
    imm_ext   = 1'b1;
    case (op)
      OP_ANDI: begin imm_aluop = ALU_AND; imm_ext = 1'b0; end
      OP_XORI: begin imm_aluop = ALU_XOR; imm_ext = 1'b0; end
      OP_SLTI: begin imm_aluop = ALU_SLT; imm_ext = 1'b1; end
      default: begin imm_aluop = ALU_ADD; imm_ext = 1'b1; end
    endcase
  end

  // Every output is held at zero while reset_n is low, not only at the edge.
  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 1'b0;
    PCToReg  = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ExtMode  = 1'b0;
    RegDst   = '0;
    ALUSrcB  = '0;
    PCSource = '0;
    aluop4   = ALU_ADD;
    error    = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          ExtMode = 1'b1;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ExtMode = 1'b1;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_REXEC: begin
          ALUSrcA = 1'b1;
          aluop4  = ALU_FUNCT;
        end
        S_RWB: begin
          RegDst   = 2'b01;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          aluop4   = ALU_SUB;
          PCSource = 2'b01;
          PCWrite  = (op == OP_BNE) ? ~zero : zero;
        end
        S_JUMP: begin
          PCSource = 2'b10;
          PCWrite  = 1'b1;
          if (op == OP_JAL) begin
            RegDst   = 2'b10;
            PCToReg  = 1'b1;
            RegWrite = 1'b1;
          end
        end
        S_IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          aluop4  = imm_aluop;
          ExtMode = imm_ext;
        end
        S_IWB: begin
          RegWrite = 1'b1;
          aluop4   = imm_aluop;
          ExtMode  = imm_ext;
        end
        S_ERROR: error = 1'b1;
        default: ;
      endcase
    end
  end

  assign ALUOp = ALUOP_W'(aluop4);
  assign state = state_q;

endmodule
